// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with hex decode, per-digit enable/dp,
// blank guard interval and PWM brightness. Optional SEG_SCAN_LZ_SUPPRESS_EN blanks leading zeros.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 64,
  parameter int PWM_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [PWM_BITS-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg_out,
  output logic                    frame_tick
);

  localparam int SW = $clog2(DIGIT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic                    snap;
  logic [NUM_DIGITS-1:0]   show;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_show;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    pwm_on;
  logic                    lit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign snap = en && (idx_q == '0) && (slot_cnt_q == '0);

  // The snapshot value is bypassed into the output path on the capture cycle,
  // so a zero-length blank guard still shows the new frame from its first cycle.
  always_comb begin
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    if (snap) begin
      sh_digits_d = digits;
      sh_dp_d     = dp_mask;
      sh_en_d     = digit_en;
    end
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  logic leading;
  always_comb begin
    show    = sh_en_d;
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (sh_digits_d[4*i +: 4] == 4'd0) && !sh_dp_d[i]) begin
        show[i] = 1'b0;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  always_comb begin
    show = sh_en_d;
  end
`endif

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_show  = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = sh_digits_d[4*i +: 4];
        cur_dp    = sh_dp_d[i];
        cur_show  = show[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign pwm_on = (bright == '1) || (pwm_cnt_q < bright);
  assign lit    = (slot_cnt_q >= BLANK_END) && cur_show && pwm_on;

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    pwm_cnt_d    = pwm_cnt_q;
    frame_tick_d = 1'b0;
    an_d         = '1;
    seg_d        = 8'hFF;
    if (en) begin
      frame_tick_d = snap;
      pwm_cnt_d    = pwm_cnt_q + 1'b1;
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
      if (lit) begin
        an_d  = an_sel;
        seg_d = {~cur_dp, decode(cur_digit)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pwm_cnt_q    <= '0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg_out    = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 40-cycle slots, 4-cycle blank, 2-bit PWM):
// frame-position model with per-cycle scoreboard plus literal spot checks.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int DC    = 40;
  localparam int BC    = 4;
  localparam int PB    = 2;
  localparam int FRAME = ND * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [1:0]  bright = 2'd0;
  logic [3:0]  an;
  logic [7:0]  seg_out;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  seg_scan_mux #(
    .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
    .digit_en(digit_en), .bright(bright), .an(an), .seg_out(seg_out),
    .frame_tick(frame_tick)
  );

  // Clock
  always #5 clk = ~clk;

  // Model: p is the count of enabled clock edges since reset release.
  int          p = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic [12:0] exp_q[$];
  logic [12:0] last_exp = {4'hF, 8'hFF, 1'b0};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  task automatic model_step();
    int fpos;
    int idx;
    int slot;
    logic [3:0] show;
    logic lit;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic lead;
`endif
    if (rst) begin
      p = 0; m_dig = '0; m_dp = '0; m_en = '0;
      exp_q.push_back({4'hF, 8'hFF, 1'b0});
      return;
    end
    if (!en) begin
      exp_q.push_back({4'hF, 8'hFF, 1'b0});
      return;
    end
    fpos = p % FRAME;
    if (fpos == 0) begin
      m_dig = digits; m_dp = dp_mask; m_en = digit_en;
    end
    idx  = fpos / DC;
    slot = p % DC;
    show = m_en;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    lead = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      if (lead && m_dig[4*i +: 4] == 4'd0 && !m_dp[i]) show[i] = 1'b0;
      else lead = 1'b0;
    end
`endif
    lit = (slot >= BC) && show[idx] &&
          ((bright == 2'b11) || ((p % (1 << PB)) < int'(bright)));
    if (lit)
      exp_q.push_back({~(4'b0001 << idx), ~m_dp[idx], glyph(m_dig[4*idx +: 4]), fpos == 0});
    else
      exp_q.push_back({4'hF, 8'hFF, fpos == 0});
    p++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare outputs every cycle at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      if (exp_q.size() == 1) last_exp = exp_q.pop_front();
      check("cycle_an_seg_tick", {an, seg_out, frame_tick}, last_exp);
    end
  end

  // Driver helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    int n = 0;
    while (an !== want && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (an !== want) check(name, an, want);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) check(name, frame_tick, 1);
  endtask

  task automatic count_frame(output int lit_n, output int d3_n, output int tick_n, input int cycles);
    lit_n = 0; d3_n = 0; tick_n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (an != 4'hF) lit_n++;
      if (an == 4'b0111) d3_n++;
      if (frame_tick) tick_n++;
    end
  endtask

  int n_lit, n_d3, n_tick, period;

  initial begin
    // Reset state
    bright = 2'd3; digit_en = 4'hF; digits = 16'h1234; dp_mask = 4'h0;
    tick(3);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg_out, 8'hFF);
    check("reset_tick", frame_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("first_tick", frame_tick, 1'b1);
    check("first_blank", an, 4'hF);

    // Basic scan of 1234: digit 0 (rightmost) is 4, digit 3 is 1
    wait_an(4'b1110, "wait_slot0");
    check("slot0_seg_1234", seg_out, 8'h99);
    wait_an(4'b0111, "wait_slot3");
    check("slot3_seg_1234", seg_out, 8'hF9);
    wait_tick("wait_tick_a");
    period = 0;
    @(negedge clk);
    period = 1;
    while (frame_tick !== 1'b1 && period < 400) begin
      @(negedge clk);
      period++;
    end
    check("frame_period", period, FRAME);

    // Hex glyphs and decimal point
    digits = 16'hABCF; dp_mask = 4'b0010;
    wait_tick("wait_tick_b");
    wait_an(4'b1101, "wait_slot1_abcf");
    check("slot1_seg_C_dp", seg_out, 8'h46);
    wait_an(4'b1110, "wait_slot0_abcf");
    check("slot0_seg_F", seg_out, 8'h8E);

    // Mid-frame input change is deferred to the next frame
    wait_tick("wait_tick_c");
    wait_an(4'b1011, "wait_slot2_mid");
    digits = 16'h1234; dp_mask = 4'h0;
    wait_an(4'b0111, "wait_slot3_old");
    check("slot3_still_A", seg_out, 8'h88);
    wait_tick("wait_tick_d");
    wait_an(4'b0111, "wait_slot3_new");
    check("slot3_new_1", seg_out, 8'hF9);

    // PWM duty: 9 lit ON-phase cycles per slot at bright=1, none at bright=0
    bright = 2'd1;
    tick(2);
    count_frame(n_lit, n_d3, n_tick, FRAME);
    check("bright1_lit_cycles", n_lit, 36);
    bright = 2'd0;
    tick(2);
    count_frame(n_lit, n_d3, n_tick, FRAME);
    check("bright0_lit_cycles", n_lit, 0);
    check("bright0_ticks", n_tick, 1);

    // Scan pause mid-slot
    bright = 2'd3;
    wait_an(4'b1101, "wait_slot1_pause");
    tick(3);
    en = 1'b0;
    tick(1);
    count_frame(n_lit, n_d3, n_tick, 100);
    check("pause_lit", n_lit, 0);
    check("pause_ticks", n_tick, 0);
    en = 1'b1;
    tick(1);
    check("resume_an", an, 4'b1101);

    // Asynchronous reset mid-slot
    wait_an(4'b1011, "wait_slot2_rst");
    #1 rst = 1'b1;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg_out, 8'hFF);
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_restart_tick", frame_tick, 1'b1);
    wait_an(4'b1110, "wait_slot0_after_rst");
    check("rst_slot0_seg", seg_out, 8'h99);

    // Leading zeros
    digits = 16'h0050; dp_mask = 4'h0;
    wait_tick("wait_tick_lz");
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    count_frame(n_lit, n_d3, n_tick, FRAME);
    check("lz_digit3_dark", n_d3, 0);
    wait_an(4'b1011, "wait_lz_slot2");
    check("lz_slot2_zero", seg_out, 8'hC0);
    wait_an(4'b1101, "wait_lz_slot1");
    check("lz_slot1_five", seg_out, 8'h92);
    dp_mask = 4'b1000;
    wait_tick("wait_tick_lz_dp");
    wait_an(4'b0111, "wait_lz_slot3_dp");
    check("lz_slot3_dp_zero", seg_out, 8'h40);
`else
    wait_an(4'b0111, "wait_nolz_slot3");
    check("nolz_slot3_zero", seg_out, 8'hC0);
    wait_an(4'b1110, "wait_nolz_slot0");
    check("nolz_slot0_zero", seg_out, 8'hC0);
`endif

    // All digits disabled: dark but still ticking
    digit_en = 4'h0;
    wait_tick("wait_tick_dark");
    count_frame(n_lit, n_d3, n_tick, FRAME);
    check("dark_lit", n_lit, 0);
    check("dark_ticks", n_tick, 1);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
